pri_enc_irq: RTL
================

PRI_ENC_IRQ -- requirements
Module: pri_enc_irq

Interface
REQ-001 Parameter: N, default 8, number of request channels; legal range 2..32.
REQ-002 Derived localparam: IDXW = $clog2(N), index width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  level request lines; bit i high at an edge sets pending bit i.
REQ-006 mask  input  N  enable per channel; 1 = channel eligible for encoding.
REQ-007 ack  input  1  consumer accepts current index; honoured only when valid=1.
REQ-008 valid  output  1  registered; 1 = at least one pending and unmasked channel.
REQ-009 y  output  IDXW  registered index of the selected channel.
REQ-010 pend  output  N  registered sticky pending vector.

Function
REQ-011 Pending update at each edge: pend_next = (pend & ~clr) | req; clr = one-hot(y) when ack & valid, else 0.
REQ-012 Same-bit ack and req at one edge: req wins, bit stays set.
REQ-013 Encoding operates on (pend_next & mask), with mask sampled at the same edge; valid and y load at that edge.
REQ-014 Latency: req or mask change at edge t is visible on valid/y immediately after edge t (1 clock); no combinational path from inputs to outputs.
REQ-015 Fixed-priority mode: highest set index wins (bit N-1 highest, bit 0 lowest).
REQ-016 No eligible channel: valid=0 and y=0 (never X).
REQ-017 ack with valid=0: ignored; pend unchanged except for new req bits.
REQ-018 Accepted ack: the next eligible index appears on y at the same edge; back-to-back acks every cycle drain one channel per clock.
REQ-019 Masked pending bits are retained, not cleared; they become eligible at the first edge where the mask bit is 1.
REQ-020 y is only meaningful while valid=1; consumers sample y with valid.

Reset
REQ-021 At an edge with rst=1: pend=0, valid=0, y=0, rotation pointer=N-1.
REQ-022 rst overrides req and ack at the same edge; requests present during reset are dropped.
REQ-023 Reset mid-drain discards all pending requests; no residual grant after reset release.

Configuration
REQ-024 Macro PRI_ENC_RR_EN defined: rotating priority. An IDXW-bit pointer p is highest priority, and priority descends p, p-1, ... 0, N-1, ..., p+1.
REQ-025 With PRI_ENC_RR_EN, an accepted ack of index k sets p = (k-1) mod N at that edge; p changes on no other event except reset.
REQ-026 With PRI_ENC_RR_EN, the reset value p=N-1 makes first-grant ordering identical to fixed priority.
REQ-027 Macro undefined: fixed priority per REQ-015; pointer logic absent from the netlist; ports are identical in both builds.

Verification (N=8)
REQ-028 Drain: rst, then req=8'h24 for 1 cycle, mask=8'hFF -> valid=1, y=5, pend=8'h24; ack -> y=2, pend=8'h04; ack -> valid=0, y=0, pend=0.
REQ-029 Mask: pend=8'h81, mask=8'h7F -> y=0, valid=1; set mask=8'hFF -> y=7 after 1 edge; pend stays 8'h81.
REQ-030 Collision and idle ack: with y=3 and valid=1, assert ack and req[3] together -> pend[3]=1 and y=3; with valid=0, ack -> no state change.
REQ-031 Reset mid-operation: pend=8'hFF, then rst=1 with req=8'hFF and ack=1 -> pend=0, valid=0, y=0 after that edge.
REQ-032 Rotation: req=8'hFF held, ack held continuously -> with PRI_ENC_RR_EN, y sequence is 7,6,5,4,3,2,1,0,7; without the macro, y=7 on every cycle.

Source files
------------

// File: rtl/pri_enc_irq.sv
// Sticky-pending interrupt priority encoder with registered valid/index outputs.
// Define PRI_ENC_RR_EN for rotating priority; the default build is fixed priority (highest index wins).
module pri_enc_irq #(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic            ack,
    output logic            valid,
    output logic [IDXW-1:0] y,
    output logic [N-1:0]    pend
);

    logic            accept;
    logic [N-1:0]    clr;
    logic [N-1:0]    pend_nxt;
    logic [N-1:0]    elig;
    logic            valid_nxt;
    logic [IDXW-1:0] y_nxt;

`ifdef PRI_ENC_RR_EN
    localparam int unsigned NU = N;

    logic [IDXW-1:0] p;
    logic [IDXW-1:0] p_nxt;
    logic            found;
    int unsigned     idx;
`endif

    always_comb begin
        accept    = ack & valid;
        clr       = accept ? (N'(1) << y) : '0;
        // New requests are OR'd in after the clear so a same-cycle re-request survives the ack.
        pend_nxt  = (pend & ~clr) | req;
        elig      = pend_nxt & mask;
        valid_nxt = |elig;
        y_nxt     = '0;
`ifdef PRI_ENC_RR_EN
        // Encode against the updated pointer so the next grant appears at the ack edge.
        p_nxt = p;
        if (accept) begin
            p_nxt = (y == '0) ? IDXW'(N - 1) : y - IDXW'(1);
        end
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NU; off++) begin
            idx = (32'(p_nxt) + NU - off) % NU;
            if (!found && elig[idx]) begin
                found = 1'b1;
                y_nxt = IDXW'(idx);
            end
        end
`else
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i]) begin
                y_nxt = IDXW'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            valid <= 1'b0;
            y     <= '0;
`ifdef PRI_ENC_RR_EN
            p     <= IDXW'(N - 1);
`endif
        end else begin
            pend  <= pend_nxt;
            valid <= valid_nxt;
            y     <= y_nxt;
`ifdef PRI_ENC_RR_EN
            p     <= p_nxt;
`endif
        end
    end

endmodule
